// File: rtl/pipe_mem_elastic.sv
`default_nettype none
// ============================================================================
// Module   : pipe_mem_elastic
// Desc     : H-stage, W-bit elastic register pipeline with per-stage valid
//            bits, valid/ready backpressure, bubble collapse and flush.
// Revision : 1.0  initial release
// ============================================================================
module pipe_mem_elastic #(
  parameter int H  = 4,
  parameter int W  = 32,
  parameter int CW = $clog2(H + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [W-1:0]  in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [W-1:0]  out_data,
  input  logic          out_ready,
  output logic [CW-1:0] count
);

  logic [H-1:0]  r_v;
  logic [W-1:0]  r_d [H];
  logic [CW-1:0] r_count;
  logic [H-1:0]  w_rdy;
  logic [H-1:0]  w_up_v;
  logic [W-1:0]  w_up_d [H];
  logic          w_in_xfer;
  logic          w_out_xfer;

  genvar i;
  generate
    for (i = 0; i < H; i++) begin : g_stage
      // Equivalent to the rippled ready chain: a stage may load when any
      // stage between it and the output is empty, or the output drains.
      assign w_rdy[i] = out_ready | ~(&r_v[H-1:i]);
      if (i == 0) begin : g_head
        assign w_up_v[i] = in_valid;
        assign w_up_d[i] = in_data;
      end else begin : g_body
        assign w_up_v[i] = r_v[i-1];
        assign w_up_d[i] = r_d[i-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_v <= '0;
      for (int k = 0; k < H; k++) r_d[k] <= '0;
    end else if (flush) begin
      r_v <= '0;
    end else begin
      for (int k = 0; k < H; k++) begin
        if (w_rdy[k]) begin
          r_v[k] <= w_up_v[k];
          // bubbles leave the data register untouched
          if (w_up_v[k]) r_d[k] <= w_up_d[k];
        end
      end
    end
  end

  assign in_ready   = w_rdy[0] & ~flush;
  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = r_v[H-1] & out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (flush) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(w_in_xfer) - CW'(w_out_xfer);
    end
  end

  assign out_valid = r_v[H-1];
  assign out_data  = r_d[H-1];
  assign count     = r_count;

endmodule
`default_nettype wire
